register_file: RTL

- Multi-entry register storage built from the existing single_register cells.
- One write port plus two independent registered read ports (A, B).
- Read side supplies the operand-fetch path for the datapath: registered read data, a valid strobe, and write-to-read bypass.
- Sits between the writeback stage (writer) and the operand-fetch stage (reader).

---
 rtl/reg_pkg.sv | 15 +
 rtl/single_register.sv | 25 ++
 rtl/register_file.sv | 89 ++++++++
 3 files changed

// File: rtl/reg_pkg.sv
// rtl/reg_pkg.sv - shared constants and address-validity rule for register_file
package reg_pkg;

  localparam int unsigned DEF_BITS  = 4;
  localparam int unsigned DEF_COUNT = 8;

  // An address names a real, writable entry: inside the array and not the
  // hardwired zero entry. Writes outside this set are dropped, reads return 0.
  function automatic logic addr_ok(input int unsigned addr,
                                   input int unsigned count,
                                   input logic        zero_reg);
    return (addr < count) && !(zero_reg && (addr == 0));
  endfunction

endpackage

// File: rtl/single_register.sv
// rtl/single_register.sv - one storage entry with write enable
module single_register #(
  parameter int unsigned bits = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            wenable,
  input  logic [bits-1:0] wdata,
  output logic [bits-1:0] rdata
);

  logic [bits-1:0] data_q;

  // Load on write strobe, clear on reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_q <= '0;
    end else if (wenable) begin
      data_q <= wdata;
    end
  end

  assign rdata = data_q;

endmodule

// File: rtl/register_file.sv
// rtl/register_file.sv - one write port, two registered read ports with write bypass
module register_file
  import reg_pkg::*;
#(
  parameter int unsigned bits     = DEF_BITS,
  parameter int unsigned count    = DEF_COUNT,
  parameter bit          zero_reg = 1'b0,
  parameter int unsigned abits    = $clog2(count)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wenable,
  input  logic [abits-1:0] waddr,
  input  logic [bits-1:0]  wdata,
  input  logic             renable_a,
  input  logic [abits-1:0] raddr_a,
  output logic [bits-1:0]  rdata_a,
  output logic             rvalid_a,
  input  logic             renable_b,
  input  logic [abits-1:0] raddr_b,
  output logic [bits-1:0]  rdata_b,
  output logic             rvalid_b
);

  logic [bits-1:0] entry_val [count];
  logic            write_ok;

  logic [bits-1:0] rdata_a_d, rdata_a_q, rdata_b_d, rdata_b_q;
  logic            rvalid_a_d, rvalid_a_q, rvalid_b_d, rvalid_b_q;

  assign write_ok = addr_ok(32'(waddr), count, zero_reg);

  for (genvar i = 0; i < count; i++) begin : g_entry
    single_register #(.bits(bits)) u_reg (
      .clk    (clk),
      .rstn   (rstn),
      .wenable(wenable && (waddr == abits'(i)) && write_ok),
      .wdata  (wdata),
      .rdata  (entry_val[i])
    );
  end

  // A valid read address implies a same-address write is also valid, so the
  // bypass compare needs no separate write_ok term.
  function automatic logic [bits-1:0] resolve(input logic [abits-1:0] addr);
    if (!addr_ok(32'(addr), count, zero_reg)) begin
      return '0;
    end else if (wenable && (waddr == addr)) begin
      return wdata;
    end else begin
      return entry_val[addr];
    end
  endfunction

  // Next read data/valid per port; data holds when no request is made.
  always_comb begin
    rdata_a_d  = rdata_a_q;
    rdata_b_d  = rdata_b_q;
    rvalid_a_d = renable_a;
    rvalid_b_d = renable_b;
    if (renable_a) begin
      rdata_a_d = resolve(raddr_a);
    end
    if (renable_b) begin
      rdata_b_d = resolve(raddr_b);
    end
  end

  // Read output registers; reset drops any pending read immediately.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata_a_q  <= '0;
      rdata_b_q  <= '0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
    end else begin
      rdata_a_q  <= rdata_a_d;
      rdata_b_q  <= rdata_b_d;
      rvalid_a_q <= rvalid_a_d;
      rvalid_b_q <= rvalid_b_d;
    end
  end

  assign rdata_a  = rdata_a_q;
  assign rdata_b  = rdata_b_q;
  assign rvalid_a = rvalid_a_q;
  assign rvalid_b = rvalid_b_q;

endmodule
